tile_scheduler: RTL

TILE_SCHEDULER -- requirements
Module: tile_scheduler

---
 rtl/tile_scheduler.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/tile_scheduler.sv
// tile_scheduler: walks an M x N x K grid of PE-array tiles (k innermost,
// then m, then n outermost), issues one go pulse per tile to the array
// controller and presents the weight / input-activation / partial-sum base
// word addresses for that tile.
// Optional build macro: TILE_SCHEDULER_PERF_EN adds the perf_cycles counter.
module tile_scheduler #(
    parameter int ARRAY_ROWS = 3,
    parameter int ARRAY_COLS = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_m_tiles,
    input  logic [CNT_W-1:0] cfg_n_tiles,
    input  logic [CNT_W-1:0] cfg_k_tiles,
    output logic             ctrl_go,
    input  logic             ctrl_done,
    output logic [31:0]      weight_base,
    output logic [31:0]      iact_base,
    output logic [31:0]      psum_base,
    output logic [CNT_W-1:0] tile_m,
    output logic [CNT_W-1:0] tile_n,
    output logic [CNT_W-1:0] tile_k,
    output logic             psum_accumulate,
    output logic             busy,
    output logic             done,
`ifdef TILE_SCHEDULER_PERF_EN
    output logic [31:0]      perf_cycles,
`endif
    output logic             err_cfg
);

    localparam int TILE_WORDS = ARRAY_ROWS * ARRAY_COLS;

    // Controller handshake: ctrl_go is a single-cycle request that launches one
    // tile; the controller answers with a single-cycle ctrl_done. Exactly one
    // request is outstanding at a time, and ctrl_done is only honoured while
    // waiting on that request.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cfg_m_q, cfg_n_q, cfg_k_q;
    logic [CNT_W-1:0] tile_m_q, tile_n_q, tile_k_q;
    logic [CNT_W-1:0] tile_m_d, tile_n_d, tile_k_d;
    logic [31:0]      weight_base_q, iact_base_q, psum_base_q;
    logic             go_q, done_q, err_q, busy_q, acc_q;
    logic             cfg_ok, k_last, m_last, n_last, last_tile;

    // (outer * count + inner) * TILE_WORDS, kept to 32 bits
    function automatic logic [31:0] tile_base(input logic [CNT_W-1:0] outer,
                                              input logic [CNT_W-1:0] count,
                                              input logic [CNT_W-1:0] inner);
        logic [31:0] idx;
        idx = 32'(outer) * 32'(count) + 32'(inner);
        return idx * 32'(TILE_WORDS);
    endfunction

    assign cfg_ok    = (cfg_m_tiles != '0) && (cfg_n_tiles != '0) && (cfg_k_tiles != '0);
    assign k_last    = (tile_k_q == cfg_k_q - CNT_W'(1));
    assign m_last    = (tile_m_q == cfg_m_q - CNT_W'(1));
    assign n_last    = (tile_n_q == cfg_n_q - CNT_W'(1));
    assign last_tile = k_last && m_last && n_last;

    // Next tile in loop order: k wraps into m, m wraps into n.
    always_comb begin
        tile_k_d = tile_k_q;
        tile_m_d = tile_m_q;
        tile_n_d = tile_n_q;
        if (!k_last) begin
            tile_k_d = tile_k_q + CNT_W'(1);
        end else begin
            tile_k_d = '0;
            if (!m_last) begin
                tile_m_d = tile_m_q + CNT_W'(1);
            end else begin
                tile_m_d = '0;
                tile_n_d = tile_n_q + CNT_W'(1);
            end
        end
    end

    // Job FSM; every output is a register so it is glitch-free at the controller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cfg_m_q       <= '0;
            cfg_n_q       <= '0;
            cfg_k_q       <= '0;
            tile_m_q      <= '0;
            tile_n_q      <= '0;
            tile_k_q      <= '0;
            weight_base_q <= '0;
            iact_base_q   <= '0;
            psum_base_q   <= '0;
            go_q          <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            acc_q         <= 1'b0;
        end else begin
            go_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            cfg_m_q       <= cfg_m_tiles;
                            cfg_n_q       <= cfg_n_tiles;
                            cfg_k_q       <= cfg_k_tiles;
                            tile_m_q      <= '0;
                            tile_n_q      <= '0;
                            tile_k_q      <= '0;
                            weight_base_q <= '0;
                            iact_base_q   <= '0;
                            psum_base_q   <= '0;
                            acc_q         <= 1'b0;
                            go_q          <= 1'b1;
                            busy_q        <= 1'b1;
                            state_q       <= ST_ISSUE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (ctrl_done) state_q <= ST_ADVANCE;
                end
                ST_ADVANCE: begin
                    if (last_tile) begin
                        // indices and bases stay on the final tile
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        tile_m_q      <= tile_m_d;
                        tile_n_q      <= tile_n_d;
                        tile_k_q      <= tile_k_d;
                        weight_base_q <= tile_base(tile_n_d, cfg_k_q, tile_k_d);
                        iact_base_q   <= tile_base(tile_m_d, cfg_k_q, tile_k_d);
                        psum_base_q   <= tile_base(tile_m_d, cfg_n_q, tile_n_d);
                        acc_q         <= (tile_k_d != '0);
                        go_q          <= 1'b1;
                        state_q       <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TILE_SCHEDULER_PERF_EN
    logic [31:0] perf_q;

    // Busy-cycle counter: restarts on an accepted job, saturates, holds in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (state_q == ST_IDLE) begin
            if (start && cfg_ok) perf_q <= '0;
        end else if (perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

    assign ctrl_go         = go_q;
    assign done            = done_q;
    assign err_cfg         = err_q;
    assign busy            = busy_q;
    assign psum_accumulate = acc_q;
    assign tile_m          = tile_m_q;
    assign tile_n          = tile_n_q;
    assign tile_k          = tile_k_q;
    assign weight_base     = weight_base_q;
    assign iact_base       = iact_base_q;
    assign psum_base       = psum_base_q;

endmodule
